// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin arbiter sharing one sequential divider among NUM_REQ requesters.
// Define DIV_ARB_TIMEOUT_EN to add a WAIT-state watchdog that answers with an error after TIMEOUT_CYCLES.
module div_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 60,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       rsp_valid_out,
  output logic [WIDTH-1:0]         rsp_quotient_out,
  output logic [WIDTH-1:0]         rsp_remainder_out,
  output logic                     rsp_error_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_valid_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_valid_in,
  input  logic                     div_error_in,
  input  logic                     div_busy_in
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t             state_r;
  logic [IDX_W-1:0]   sel_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   pick_s;
  logic               pick_found_s;
  logic [NUM_REQ-1:0] ready_r;
  logic [WIDTH-1:0]   dividend_r [NUM_REQ];
  logic [WIDTH-1:0]   divisor_r  [NUM_REQ];
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [WIDTH-1:0]   rsp_quotient_r;
  logic [WIDTH-1:0]   rsp_remainder_r;
  logic               rsp_error_r;
  logic [WIDTH-1:0]   div_dividend_r;
  logic [WIDTH-1:0]   div_divisor_r;
  logic               div_valid_r;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;
`endif

  assign req_ready_out     = ready_r;
  assign rsp_valid_out     = rsp_valid_r;
  assign rsp_quotient_out  = rsp_quotient_r;
  assign rsp_remainder_out = rsp_remainder_r;
  assign rsp_error_out     = rsp_error_r;
  assign div_dividend_out  = div_dividend_r;
  assign div_divisor_out   = div_divisor_r;
  assign div_valid_out     = div_valid_r;

  // Round-robin search: first pending slot at or after rr_ptr_r, wrapping modulo NUM_REQ.
  always_comb begin
    pick_s       = {IDX_W{1'b0}};
    pick_found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_s = (!pick_found_s && !ready_r[(int'(rr_ptr_r) + k) % NUM_REQ])
               ? IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ) : pick_s;
      pick_found_s = pick_found_s || !ready_r[(int'(rr_ptr_r) + k) % NUM_REQ];
    end
  end

  // Pending slots: latch operands on accept, release the served slot while leaving RESPOND.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ready_r <= {NUM_REQ{1'b1}};
      for (int i = 0; i < NUM_REQ; i++) begin
        dividend_r[i] <= {WIDTH{1'b0}};
        divisor_r[i]  <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((state_r == RESPOND) && (int'(sel_r) == i)) begin
          ready_r[i] <= 1'b1;
        end else if (req_valid_in[i] && ready_r[i]) begin
          ready_r[i]    <= 1'b0;
          dividend_r[i] <= req_dividend_in[i*WIDTH +: WIDTH];
          divisor_r[i]  <= req_divisor_in[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Arbitration FSM driving the divider and the shared response bus.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r         <= IDLE;
      sel_r           <= {IDX_W{1'b0}};
      rr_ptr_r        <= {IDX_W{1'b0}};
      rsp_valid_r     <= {NUM_REQ{1'b0}};
      rsp_quotient_r  <= {WIDTH{1'b0}};
      rsp_remainder_r <= {WIDTH{1'b0}};
      rsp_error_r     <= 1'b0;
      div_dividend_r  <= {WIDTH{1'b0}};
      div_divisor_r   <= {WIDTH{1'b0}};
      div_valid_r     <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
      wait_cnt_r      <= {CNT_W{1'b0}};
`endif
    end else begin
      rsp_valid_r <= {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (pick_found_s && !div_busy_in) begin
            sel_r          <= pick_s;
            div_dividend_r <= dividend_r[pick_s];
            div_divisor_r  <= divisor_r[pick_s];
            div_valid_r    <= 1'b1;
            state_r        <= ISSUE;
          end
        end
        ISSUE: begin
          div_valid_r <= 1'b0;
          state_r     <= WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
          wait_cnt_r  <= {CNT_W{1'b0}};
`endif
        end
        WAIT: begin
          if (div_valid_in) begin
            rsp_quotient_r     <= div_quotient_in;
            rsp_remainder_r    <= div_remainder_in;
            rsp_error_r        <= div_error_in;
            rsp_valid_r[sel_r] <= 1'b1;
            state_r            <= RESPOND;
`ifdef DIV_ARB_TIMEOUT_EN
          end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Divider never answered: report an error with zeroed results.
            rsp_quotient_r     <= {WIDTH{1'b0}};
            rsp_remainder_r    <= {WIDTH{1'b0}};
            rsp_error_r        <= 1'b1;
            rsp_valid_r[sel_r] <= 1'b1;
            state_r            <= RESPOND;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
`endif
          end
        end
        RESPOND: begin
          rr_ptr_r <= (sel_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : sel_r + IDX_W'(1);
          state_r  <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          div_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
